// File: rtl/race_decode_16.sv
// Temporal-to-binary decoder for race-coded lines: timestamps each line's first low
// level against a window counter and presents all values through a valid/ready handshake.
module race_decode_16 #(
    parameter int unsigned N     = 16,
    parameter int unsigned W     = 6,
    parameter int unsigned MAX_T = 63
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N-1:0]     lines,
    output logic [N*W-1:0]   values,
    output logic [N-1:0]     arrived,
    output logic             timeout,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {StIdle, StCount, StDone} state_e;

    localparam logic [W-1:0] MaxT = W'(MAX_T);

    state_e         state;
    logic [W-1:0]   t;
    logic [N-1:0]   arrived_next;

    // Captures made on this edge count towards the exit decision on the same edge.
    always_comb begin
        arrived_next = arrived | ~lines;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            t         <= '0;
            values    <= '0;
            arrived   <= '0;
            timeout   <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        t       <= '0;
                        values  <= '0;
                        arrived <= '0;
                        timeout <= 1'b0;
                        busy    <= 1'b1;
                        state   <= StCount;
                    end
                end
                StCount: begin
                    for (int unsigned i = 0; i < N; i++) begin
                        if (!lines[i] && !arrived[i]) begin
                            values[i*W +: W] <= t;
                        end
                    end
                    arrived <= arrived_next;
                    if (&arrived_next) begin
                        timeout   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= StDone;
                    end else if (t == MaxT) begin
                        for (int unsigned i = 0; i < N; i++) begin
                            if (!arrived_next[i]) begin
                                values[i*W +: W] <= MaxT;
                            end
                        end
                        timeout   <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= StDone;
                    end else begin
                        t <= t + 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_race_decode_16.sv
// Directed, table-driven bench for race_decode_16 with hand-written sequences for the
// DONE-hold and mid-window reset corner cases.
module tb_race_decode_16;

    localparam int N = 16;
    localparam int W = 6;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [N-1:0]    lines;
    logic [N*W-1:0]  values;
    logic [N-1:0]    arrived;
    logic            timeout;
    logic            busy;
    logic            out_valid;
    logic            out_ready;

    int checks;
    int errors;

    race_decode_16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .lines     (lines),
        .values    (values),
        .arrived   (arrived),
        .timeout   (timeout),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // fall = 255 means the line never falls; rise = 255 means it never returns high.
    typedef struct packed {
        logic [15:0][7:0] fall;
        logic [15:0][7:0] rise;
        logic [15:0]      pre;
        logic [7:0]       done;
        logic [15:0]      arr;
        logic             to;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t uniform(input logic [7:0] f);
        vec_t v;
        for (int i = 0; i < N; i++) begin
            v.fall[i] = f;
            v.rise[i] = 8'd255;
        end
        v.pre  = '0;
        v.done = f;
        v.arr  = 16'hFFFF;
        v.to   = 1'b0;
        return v;
    endfunction

    function automatic logic [N-1:0] pattern(input vec_t v, input int k);
        logic [N-1:0] p;
        for (int i = 0; i < N; i++) begin
            if (v.pre[i]) p[i] = !(k < int'(v.rise[i]));
            else          p[i] = !(int'(v.fall[i]) <= k && k < int'(v.rise[i]));
        end
        return p;
    endfunction

    function automatic logic [N*W-1:0] exp_values(input vec_t v);
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) begin
            if (v.pre[i])                  r[i*W +: W] = '0;
            else if (v.fall[i] > 8'd63)    r[i*W +: W] = 6'd63;
            else                           r[i*W +: W] = v.fall[i][W-1:0];
        end
        return r;
    endfunction

    // Opens a window and waits for out_valid; leaves the DUT in DONE with out_ready low.
    task automatic run_window(input vec_t v, input string name);
        int done_k;
        done_k = -1;
        @(negedge clk);
        lines = pattern(v, -1);
        start = 1'b1;
        @(posedge clk);
        #1;
        chk({name, "_busy_start"}, 128'(busy), 128'(1'b1));
        chk({name, "_cleared"}, 128'({arrived, timeout, out_valid}), 128'(0));
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            start = 1'b0;
            lines = pattern(v, k);
            @(posedge clk);
            #1;
            if (out_valid) begin
                done_k = k;
                break;
            end
        end
        chk({name, "_done_edge"}, 128'(done_k), 128'(int'(v.done)));
        chk({name, "_values"}, 128'(values), 128'(exp_values(v)));
        chk({name, "_arrived"}, 128'(arrived), 128'(v.arr));
        chk({name, "_timeout"}, 128'(timeout), 128'(v.to));
    endtask

    task automatic accept(input string name);
        @(negedge clk);
        out_ready = 1'b1;
        lines     = '1;
        @(posedge clk);
        #1;
        chk({name, "_idle_after_accept"}, 128'({busy, out_valid}), 128'(0));
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int sorter_k [16] = '{14, 5, 22, 17, 30, 10, 26, 19, 33, 39, 28, 24, 11, 7, 36, 15};
        vec_t v;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        lines     = '1;
        out_ready = 1'b0;

        vecs[0] = uniform(8'd0);
        for (int i = 0; i < N; i++) vecs[0].fall[i] = 8'(sorter_k[i]);
        vecs[0].done = 8'd39;
        vecs[1] = uniform(8'd20);
        vecs[1].fall[3] = 8'd12;
        vecs[1].fall[7] = 8'd12;
        vecs[2] = uniform(8'd2);
        vecs[2].pre[4]  = 1'b1;
        vecs[2].fall[9] = 8'd8;
        vecs[2].rise[9] = 8'd9;
        vecs[2].done    = 8'd8;
        vecs[3] = uniform(8'd3);
        vecs[3].fall[15] = 8'd255;
        vecs[3].done     = 8'd63;
        vecs[3].arr      = 16'h7FFF;
        vecs[3].to       = 1'b1;
        vecs[4] = uniform(8'd0);
        vecs[4].pre = 16'hFFFF;
        vecs[5] = uniform(8'd1);
        vecs[5].fall[0] = 8'd63;
        vecs[5].done    = 8'd63;

        #12;
        chk("reset_outputs", 128'({values, arrived, timeout, busy, out_valid}), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 6; n++) begin
            run_window(vecs[n], $sformatf("vec%0d", n));
            accept($sformatf("vec%0d", n));
        end

        // DONE hold: result stays put, start is ignored, lines are ignored.
        run_window(vecs[1], "hold");
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            start = (c == 3);
            lines = 16'($urandom);
            @(posedge clk);
            #1;
            chk("hold_valid_busy", 128'({out_valid, busy}), 128'(2'b11));
            chk("hold_values", 128'(values), 128'(exp_values(vecs[1])));
            chk("hold_arrived", 128'({arrived, timeout}), 128'({16'hFFFF, 1'b0}));
        end
        @(negedge clk);
        start = 1'b0;
        accept("hold");
        chk("hold_values_kept", 128'(values), 128'(exp_values(vecs[1])));
        run_window(vecs[4], "restart");
        accept("restart");

        // Mid-window reset at k=15 with lines 0..3 arrived at k=3.
        v = uniform(8'd255);
        for (int i = 0; i < 4; i++) v.fall[i] = 8'd3;
        @(negedge clk);
        lines = '1;
        start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            start = 1'b0;
            lines = pattern(v, k);
            @(posedge clk);
        end
        #1;
        chk("pre_reset_arrived", 128'({arrived, busy, out_valid}), 128'({16'h000F, 2'b10}));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_reset_clear", 128'({values, arrived, timeout, busy, out_valid}), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        lines = '1;
        run_window(vecs[0], "after_reset");
        accept("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
